// File: rtl/comp_seq_ctrl.sv
// Byte-serial sequencer driving a start/done XNOR comparator over a word pair.
// Optional: define COMP_SEQ_ERR_CNT_EN for a saturating mismatch-word counter.
module comp_seq_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [WORD_BYTES*DATA_WIDTH-1:0] word_a,
  input  logic [WORD_BYTES*DATA_WIDTH-1:0] word_b,
  output logic [DATA_WIDTH-1:0]            cmp_byte_a,
  output logic [DATA_WIDTH-1:0]            cmp_byte_b,
  output logic                             cmp_start,
  input  logic [DATA_WIDTH-1:0]            cmp_result,
  input  logic                             cmp_done,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_equal,
  output logic [WORD_BYTES-1:0]            rsp_mask,
  output logic [$clog2(WORD_BYTES)-1:0]    rsp_first_miss,
  output logic                             rsp_timeout,
  output logic [15:0]                      err_count
);

  localparam int IDX_W  = $clog2(WORD_BYTES);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WORD_W = WORD_BYTES * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;

  logic [WORD_W-1:0]     a_q, b_q;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [CNT_W-1:0]      cnt;
  logic [WORD_BYTES-1:0] mask;
  logic                  tout;
  logic                  last;
  logic                  expired;

  assign idx_nx  = idx + 1'b1;
  assign last    = (idx == IDX_W'(WORD_BYTES - 1));
  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    cmp_start = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = ISSUE;
      end
      ISSUE: begin
        cmp_start = 1'b1;
        state_n   = WAIT;
      end
      WAIT: begin
        if (cmp_done) begin
          state_n = last ? RESP : ISSUE;
        end else if (expired) begin
          state_n = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Byte lanes are loaded on every entry to ISSUE and held through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      cnt        <= '0;
      mask       <= '0;
      tout       <= 1'b0;
      cmp_byte_a <= '0;
      cmp_byte_b <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_q        <= word_a;
            b_q        <= word_b;
            idx        <= '0;
            mask       <= '0;
            tout       <= 1'b0;
            cmp_byte_a <= word_a[DATA_WIDTH-1:0];
            cmp_byte_b <= word_b[DATA_WIDTH-1:0];
          end
        end
        ISSUE: begin
          cnt <= '0;
        end
        WAIT: begin
          if (cmp_done) begin
            mask[idx] <= &cmp_result;
            if (!last) begin
              idx        <= idx_nx;
              cmp_byte_a <= a_q[idx_nx*DATA_WIDTH +: DATA_WIDTH];
              cmp_byte_b <= b_q[idx_nx*DATA_WIDTH +: DATA_WIDTH];
            end
          end else if (expired) begin
            tout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rsp_first_miss = '0;
    for (int k = WORD_BYTES - 1; k >= 0; k--) begin
      if (!mask[k]) rsp_first_miss = IDX_W'(k);
    end
  end

  assign rsp_mask    = mask;
  assign rsp_timeout = tout;
  assign rsp_equal   = (&mask) & ~tout;

`ifdef COMP_SEQ_ERR_CNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (rsp_valid && rsp_ready && !rsp_equal
                 && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Scoreboard bench for comp_seq_ctrl with a behavioural byte comparator.
// Responses and comparator start bytes are checked by independent monitors.
module tb_comp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] word_a = '0;
  logic [31:0] word_b = '0;
  logic [7:0]  cmp_byte_a, cmp_byte_b;
  logic        cmp_start;
  logic [7:0]  cmp_result;
  logic        cmp_done;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_equal;
  logic [3:0]  rsp_mask;
  logic [1:0]  rsp_first_miss;
  logic        rsp_timeout;
  logic [15:0] err_count;

  logic        done_m = 1'b0;
  logic        stray_done = 1'b0;
  logic [7:0]  res_m = '0;

  assign cmp_done   = done_m | stray_done;
  assign cmp_result = res_m;

  int tests = 0;
  int fails = 0;

  int cmp_delay = 1;
  int drop_byte = -1;
  bit spoof = 1'b0;
  int byte_seq = 0;

  typedef struct {
    logic [3:0] mask;
    logic       eq;
    logic [1:0] fm;
    logic       to;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ea_q[$];
  logic [7:0] eb_q[$];

  comp_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .word_a         (word_a),
    .word_b         (word_b),
    .cmp_byte_a     (cmp_byte_a),
    .cmp_byte_b     (cmp_byte_b),
    .cmp_start      (cmp_start),
    .cmp_result     (cmp_result),
    .cmp_done       (cmp_done),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_equal      (rsp_equal),
    .rsp_mask       (rsp_mask),
    .rsp_first_miss (rsp_first_miss),
    .rsp_timeout    (rsp_timeout),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Comparator model: answers cmp_delay cycles after each start pulse.
  initial begin
    logic [7:0] a, b;
    int         me;
    forever begin
      @(negedge clk);
      if (rst_n && cmp_start === 1'b1) begin
        a  = cmp_byte_a;
        b  = cmp_byte_b;
        me = byte_seq;
        byte_seq++;
        if (ea_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_start: byte %0h/%0h", a, b);
        end else begin
          chk("start_byte_a", 32'(a), 32'(ea_q.pop_front()));
          chk("start_byte_b", 32'(b), 32'(eb_q.pop_front()));
        end
        if (spoof) begin
          done_m = 1'b1;
          res_m  = 8'hFF;
        end
        for (int k = 0; k < cmp_delay; k++) begin
          @(posedge clk);
          #1;
          done_m = 1'b0;
        end
        if (me != drop_byte) begin
          done_m = 1'b1;
          res_m  = ~(a ^ b);
          @(posedge clk);
          #1;
          done_m = 1'b0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t        e;
    logic [15:0] exp_err;
    exp_err = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_err = '0;
      end else if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: mask %b", rsp_mask);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_mask", 32'(rsp_mask), 32'(e.mask));
          chk("rsp_equal", 32'(rsp_equal), 32'(e.eq));
          chk("rsp_first_miss", 32'(rsp_first_miss), 32'(e.fm));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          chk("err_count", 32'(err_count), 32'(exp_err));
`ifdef COMP_SEQ_ERR_CNT_EN
          if (!e.eq && exp_err != 16'hFFFF) exp_err++;
`endif
        end
      end
    end
  end

  // lat < 0: return right after the request handshake.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input int nbytes, input bit push, input exp_t e,
                      input int lat);
    int n;
    byte_seq = 0;
    for (int i = 0; i < nbytes; i++) begin
      ea_q.push_back(a[i*8 +: 8]);
      eb_q.push_back(b[i*8 +: 8]);
    end
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    word_a    = a;
    word_b    = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_accept: req_ready stuck low");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    word_a    = 32'h5A5A5A5A;
    word_b    = 32'hA5A5A5A5;
    if (lat < 0) return;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    if (lat > 0) chk("rsp_latency", 32'(n), 32'(lat));
    if (!rsp_ready) return;
    n = 0;
    while (rsp_valid && n < 50) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("rsp_released", 32'(rsp_valid), 32'd0);
  endtask

  function automatic exp_t mk(input logic [3:0] m, input logic eq,
                              input logic [1:0] fm, input logic to);
    exp_t e;
    e.mask = m;
    e.eq   = eq;
    e.fm   = fm;
    e.to   = to;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmp_start", 32'(cmp_start), 32'd0);
    chk("rst_rsp_mask", 32'(rsp_mask), 32'd0);
    chk("rst_rsp_equal", 32'(rsp_equal), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(32'hDEADBEEF, 32'hDEADBEEF, 4, 1'b1, mk(4'b1111, 1, 0, 0), 8);
    send(32'h12345678, 32'h12FF5670, 4, 1'b1, mk(4'b1010, 0, 0, 0), 8);
    send(32'h11223344, 32'h99223344, 4, 1'b1, mk(4'b0111, 0, 3, 0), 8);

    drop_byte = 2;
    send(32'hA5A5A5A5, 32'hA5A5A5A5, 3, 1'b1, mk(4'b0011, 0, 2, 1), 21);
    drop_byte = -1;

    rsp_ready = 1'b0;
    send(32'h00000000, 32'h00000100, 4, 1'b1, mk(4'b1101, 0, 1, 0), 8);
    req_valid = 1'b1;
    word_a    = 32'h77777777;
    word_b    = 32'h77777777;
    repeat (5) begin
      @(negedge clk);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_mask", 32'(rsp_mask), 32'h0000000D);
      chk("hold_first_miss", 32'(rsp_first_miss), 32'd1);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_req_ready", 32'(req_ready), 32'd1);

    cmp_delay = 3;
    send(32'h11223344, 32'h11223344, 2, 1'b0, mk(4'b1111, 1, 0, 0), -1);
    n = 0;
    while (byte_seq < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_byte1", 32'(byte_seq), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_cmp_start", 32'(cmp_start), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_byte_a", 32'(cmp_byte_a), 32'd0);
    chk("arst_byte_b", 32'(cmp_byte_b), 32'd0);
    chk("arst_rsp_mask", 32'(rsp_mask), 32'd0);
    chk("arst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_delay = 1;
    send(32'hCAFEF00D, 32'hCAFEF00D, 4, 1'b1, mk(4'b1111, 1, 0, 0), 8);

    @(posedge clk);
    #1 stray_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray_done = 1'b0;
    @(negedge clk);
    chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray_req_ready", 32'(req_ready), 32'd1);

    spoof     = 1'b1;
    cmp_delay = 2;
    send(32'h01020304, 32'h01020305, 4, 1'b1, mk(4'b1110, 0, 0, 0), 12);
    spoof     = 1'b0;
    cmp_delay = 1;

    repeat (5) @(posedge clk);
    #1;
    chk("rsp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("byte_queue_empty", 32'(ea_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
